pipe_stall_ctrl: RTL

Parametrised pipeline hazard controller for the in-order CPU core. It generalises per-stage stall generation to NSTAGE stages and adds three things:
- a timed multi-cycle hold channel for fixed-latency units (divider, slow memory);
- a registered pipeline flush with redirect PC, for exceptions and eret;
- a stall watchdog.

Stall outputs feed every pipeline register; flush and new_pc feed the pc and stage registers.

---
 rtl/pipe_stall_ctrl_pkg.sv | 26 ++
 rtl/pipe_hold_timer.sv | 42 ++++
 rtl/pipe_stall_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// stall levels, reset level and the flush FSM state type.
package pipe_stall_ctrl_pkg;

  typedef enum int {
    STAGE_PC  = 0,
    STAGE_IF  = 1,
    STAGE_ID  = 2,
    STAGE_EX  = 3,
    STAGE_MEM = 4,
    STAGE_WB  = 5
  } stage_e;

  typedef enum logic {
    NO_STOP = 1'b0,
    STOP    = 1'b1
  } stop_e;

  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/pipe_hold_timer.sv
// Timed multi-cycle hold: latches a stall mask and counts it down, so the
// mask contributes to stall for exactly len_in cycles after the load edge.
module pipe_hold_timer
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int NSTAGE = 6,
  parameter int HOLD_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [NSTAGE-1:0] mask_in,
  input  logic [HOLD_W-1:0] len_in,
  output logic              active,
  output logic [NSTAGE-1:0] mask_out
);

  localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

  logic [HOLD_W-1:0] count_reg;
  logic [NSTAGE-1:0] mask_reg;

  // clear beats load so a flush at the same edge discards a new hold
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      count_reg <= '0;
      mask_reg  <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= len_in;
      mask_reg  <= mask_in;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CNT_ONE;
    end
  end

  assign active   = (count_reg != '0);
  assign mask_out = active ? mask_reg : '0;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: per-stage stall masks, timed holds,
// registered flush with redirect PC, and a sticky stall watchdog.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int NSTAGE       = 6,
  parameter int HOLD_W       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT      = 1024,
  parameter int ADDR_W       = 32,
  localparam int SEL_W       = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              hold_start,
  input  logic [SEL_W-1:0]  hold_stage,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              flush_req,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              hold_active,
  output logic              stall_timeout
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  // mask(k): stage k and every stage upstream of it
  function automatic logic [NSTAGE-1:0] stage_mask(input int k);
    logic [NSTAGE-1:0] m;
    for (int i = 0; i < NSTAGE; i++) begin
      m[i] = (i <= k);
    end
    return m;
  endfunction

  int                req_top;
  logic              req_any;
  logic [NSTAGE-1:0] req_mask;
  logic [NSTAGE-1:0] hold_mask;
  logic              hold_act;
  logic              hold_valid;

  always_comb begin
    req_top = 0;
    req_any = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stallreq[i]) begin
        req_top = i;
        req_any = 1'b1;
      end
    end
    req_mask = req_any ? stage_mask(req_top) : '0;
  end

  assign hold_valid = hold_start && (hold_len != '0) && (int'(hold_stage) < NSTAGE);

  pipe_hold_timer #(
    .NSTAGE (NSTAGE),
    .HOLD_W (HOLD_W)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_valid),
    .clear    (flush_req),
    .mask_in  (stage_mask(int'(hold_stage))),
    .len_in   (hold_len),
    .active   (hold_act),
    .mask_out (hold_mask)
  );

  flush_state_t      state_reg;
  logic [FC_W-1:0]   fcnt_reg;
  logic              flush_reg;
  logic [ADDR_W-1:0] pc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_reg <= ST_IDLE;
      fcnt_reg  <= '0;
      flush_reg <= 1'b0;
      pc_reg    <= '0;
    end else if (flush_req) begin
      state_reg <= ST_FLUSH;
      fcnt_reg  <= FC_LOAD;
      flush_reg <= 1'b1;
      pc_reg    <= flush_pc;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          flush_reg <= 1'b0;
        end
        ST_FLUSH: begin
          if (fcnt_reg == FC_ONE) begin
            state_reg <= ST_IDLE;
            fcnt_reg  <= '0;
            flush_reg <= 1'b0;
          end else begin
            fcnt_reg <= fcnt_reg - FC_ONE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stall
    assign stall[gi] = (!flush_reg && (req_mask[gi] || hold_mask[gi])) ? STOP : NO_STOP;
  end

  logic [WD_W-1:0] wd_reg;
  logic            timeout_reg;

  // the flag rises at the edge that completes the TIMEOUT-th stalled cycle
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (flush_reg || !stall[STAGE_PC]) begin
        wd_reg <= '0;
      end else if (wd_reg != WD_MAX) begin
        wd_reg <= wd_reg + WD_ONE;
      end
      if (flush_reg) begin
        timeout_reg <= 1'b0;
      end else if (stall[STAGE_PC] && (wd_reg >= WD_MAX - WD_ONE)) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign flush         = flush_reg;
  assign new_pc        = pc_reg;
  assign hold_active   = hold_act;
  assign stall_timeout = timeout_reg;

endmodule
